// File: rtl/spart_pkg.sv
// rtl/spart_pkg.sv - shared address map, register bit indices and reset divisor for the SPART bus controller
//
// Purpose : constants and types used by spart_bus_ctrl and its FIFOs.
// Contents: ioaddr_e (I/O address decode), status/command bit indices,
//           SPART_DEF_DIVISOR (9600 baud at 50 MHz with n=4).
package spart_pkg;

  typedef enum logic [1:0] {
    ADDR_DATA = 2'b00,
    ADDR_STAT = 2'b01,
    ADDR_DBL  = 2'b10,
    ADDR_DBH  = 2'b11
  } ioaddr_e;

  // Status register bit positions (read at ADDR_STAT)
  localparam int ST_TX_SPACE = 0;
  localparam int ST_RX_AVAIL = 1;
  localparam int ST_RX_OVR   = 2;
  localparam int ST_TX_IDLE  = 3;
  localparam int ST_TX_OVF   = 4;
  localparam int ST_ENABLE   = 5;

  // Command register bit positions (written at ADDR_STAT)
  localparam int CMD_ENABLE     = 0;
  localparam int CMD_CLR_RX_OVR = 2;
  localparam int CMD_CLR_TX_OVF = 4;

  localparam logic [15:0] SPART_DEF_DIVISOR = 16'd326;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with combinational head output
//
// Purpose: small buffer used for both the TX and RX byte queues.
// Ports  : clk/rst (async active-high), push/wdata enqueue, pop dequeue,
//          rdata = current head, full/empty flags, count = occupancy.
// A push while full is only honoured when a pop happens the same cycle;
// a pop while empty is ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             push_eff, pop_eff;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));
  assign count = cnt_q;
  assign rdata = mem[rd_q];

  assign pop_eff  = pop & ~empty;
  assign push_eff = push & (~full | pop_eff);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    // Pointers wrap naturally because DEPTH is a power of two.
    if (push_eff) wr_d = wr_q + 1'b1;
    if (pop_eff)  rd_d = rd_q + 1'b1;
    case ({push_eff, pop_eff})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by cnt_q.
  always_ff @(posedge clk) begin
    if (push_eff) mem[wr_q] <= wdata;
  end

endmodule

// File: rtl/spart_bus_ctrl.sv
// rtl/spart_bus_ctrl.sv - SPART CPU register decode, baud divisor and TX/RX byte buffering
//
// Purpose: decodes the 2-bit I/O space, holds the baud divisor (staged low
//          byte, atomic commit on high-byte write), buffers TX/RX bytes and
//          reports status.
// Ports  : clk, rst (async active-high)
//          iocs/iorw/ioaddr/wdata -> CPU access, rdata combinational read data
//          divisor/baud_load/baud_en -> baud generator
//          tx_data/tx_valid/tx_ready/tx_busy -> TX shift engine
//          rx_data/rx_valid -> RX shift engine
module spart_bus_ctrl
  import spart_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] DEF_DIVISOR = SPART_DEF_DIVISOR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        iocs,
  input  logic        iorw,
  input  logic [1:0]  ioaddr,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic [15:0] divisor,
  output logic        baud_load,
  output logic        baud_en,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic        tx_busy,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  ioaddr_e addr;
  logic    wr, rd;
  logic    data_wr, data_rd, cmd_wr, dbl_wr, dbh_wr;

  logic        en_q, en_d;
  logic        tx_ovf_q, tx_ovf_d;
  logic        rx_ovr_q, rx_ovr_d;
  logic [15:0] div_q, div_d;
  logic [7:0]  stage_q, stage_d;
  logic        bl_q, bl_d;

  logic          tx_push, tx_pop, tx_full, tx_empty;
  logic          rx_push, rx_pop, rx_full, rx_empty, rx_drop;
  logic [7:0]    rx_head;
  logic [CW-1:0] tx_count, rx_count;
  logic [7:0]    status;

  assign addr    = ioaddr_e'(ioaddr);
  assign wr      = iocs & ~iorw;
  assign rd      = iocs & iorw;
  assign data_wr = wr & (addr == ADDR_DATA);
  assign data_rd = rd & (addr == ADDR_DATA);
  assign cmd_wr  = wr & (addr == ADDR_STAT);
  assign dbl_wr  = wr & (addr == ADDR_DBL);
  assign dbh_wr  = wr & (addr == ADDR_DBH);

  // TX: fullness is judged before the engine's same-cycle pop, so a write
  // into a full FIFO is dropped even if a slot frees up on this edge.
  assign tx_valid = en_q & ~tx_empty;
  assign tx_pop   = tx_valid & tx_ready;
  assign tx_push  = data_wr & ~tx_full;

  // RX: a same-cycle CPU read frees a slot, so the incoming byte is kept.
  assign rx_pop  = data_rd & ~rx_empty;
  assign rx_push = rx_valid & en_q & (~rx_full | rx_pop);
  assign rx_drop = rx_valid & en_q & rx_full & ~rx_pop;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .pop   (tx_pop),
    .wdata (wdata),
    .rdata (tx_data),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .pop   (rx_pop),
    .wdata (rx_data),
    .rdata (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  always_comb begin
    status              = '0;
    status[ST_TX_SPACE] = ~tx_full;
    status[ST_RX_AVAIL] = (rx_count != '0);
    status[ST_RX_OVR]   = rx_ovr_q;
    status[ST_TX_IDLE]  = (tx_count == '0) & ~tx_busy;
    status[ST_TX_OVF]   = tx_ovf_q;
    status[ST_ENABLE]   = en_q;
  end

  always_comb begin
    rdata = '0;
    case (addr)
      ADDR_DATA: rdata = rx_empty ? 8'h00 : rx_head;
      ADDR_STAT: rdata = status;
      ADDR_DBL:  rdata = div_q[7:0];
      ADDR_DBH:  rdata = div_q[15:8];
      default:   rdata = '0;
    endcase
  end

  always_comb begin
    en_d     = en_q;
    tx_ovf_d = tx_ovf_q;
    rx_ovr_d = rx_ovr_q;
    div_d    = div_q;
    stage_d  = stage_q;
    bl_d     = dbh_wr;

    if (cmd_wr) begin
      en_d = wdata[CMD_ENABLE];
      if (wdata[CMD_CLR_RX_OVR]) rx_ovr_d = 1'b0;
      if (wdata[CMD_CLR_TX_OVF]) tx_ovf_d = 1'b0;
    end
    // A fresh overrun on the same edge as a clear wins, so it is not lost.
    if (rx_drop)            rx_ovr_d = 1'b1;
    if (data_wr && tx_full) tx_ovf_d = 1'b1;

    if (dbl_wr) stage_d = wdata;
    if (dbh_wr) div_d   = {wdata, stage_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q     <= 1'b0;
      tx_ovf_q <= 1'b0;
      rx_ovr_q <= 1'b0;
      div_q    <= DEF_DIVISOR;
      stage_q  <= DEF_DIVISOR[7:0];
      bl_q     <= 1'b0;
    end else begin
      en_q     <= en_d;
      tx_ovf_q <= tx_ovf_d;
      rx_ovr_q <= rx_ovr_d;
      div_q    <= div_d;
      stage_q  <= stage_d;
      bl_q     <= bl_d;
    end
  end

  assign divisor   = div_q;
  assign baud_load = bl_q;
  assign baud_en   = en_q;

endmodule

// File: tb/tb_spart_bus_ctrl.sv
// tb/tb_spart_bus_ctrl.sv - self-checking bench for spart_bus_ctrl against a queue-based reference model
module tb_spart_bus_ctrl;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        iocs, iorw;
  logic [1:0]  ioaddr;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic [15:0] divisor;
  logic        baud_load, baud_en;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready, tx_busy;
  logic [7:0]  rx_data;
  logic        rx_valid;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [7:0]  txq[$];
  logic [7:0]  rxq[$];
  bit          m_en, m_txovf, m_rxovr, m_bl;
  logic [15:0] m_div;
  logic [7:0]  m_stage;

  spart_bus_ctrl #(.FIFO_DEPTH(D), .DEF_DIVISOR(16'd326)) dut (
    .clk       (clk),
    .rst       (rst),
    .iocs      (iocs),
    .iorw      (iorw),
    .ioaddr    (ioaddr),
    .wdata     (wdata),
    .rdata     (rdata),
    .divisor   (divisor),
    .baud_load (baud_load),
    .baud_en   (baud_en),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_busy   (tx_busy),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    txq.delete();
    rxq.delete();
    m_en = 0; m_txovf = 0; m_rxovr = 0; m_bl = 0;
    m_div = 16'd326;
    m_stage = 8'd70;
  endtask

  function automatic logic [7:0] m_status(input bit busy);
    logic [7:0] s;
    s = 8'h00;
    s[0] = (txq.size() < D);
    s[1] = (rxq.size() > 0);
    s[2] = m_rxovr;
    s[3] = (txq.size() == 0) && !busy;
    s[4] = m_txovf;
    s[5] = m_en;
    return s;
  endfunction

  // One bus cycle: drive at the falling edge, check settled outputs against
  // the model, advance the model by the rules of one rising edge.
  task automatic step(input logic cs, input logic rw, input logic [1:0] a, input logic [7:0] wd,
                      input logic trdy, input logic tbusy, input logic rxv, input logic [7:0] rxd,
                      input int lit = -1);
    logic [7:0] exp_rd;
    bit wr, rd, en_old, rpop;
    int pre_tx, pre_rx;
    iocs = cs; iorw = rw; ioaddr = a; wdata = wd;
    tx_ready = trdy; tx_busy = tbusy; rx_valid = rxv; rx_data = rxd;
    #1;
    pre_tx = txq.size();
    pre_rx = rxq.size();
    case (a)
      2'd0:    exp_rd = (pre_rx > 0) ? rxq[0] : 8'h00;
      2'd1:    exp_rd = m_status(tbusy);
      2'd2:    exp_rd = m_div[7:0];
      default: exp_rd = m_div[15:8];
    endcase
    chk("rdata", {8'h00, rdata}, {8'h00, exp_rd});
    if (lit >= 0) chk("rdata_lit", {8'h00, rdata}, 16'(lit));
    chk("tx_valid", {15'h0, tx_valid}, {15'h0, (m_en && pre_tx > 0)});
    if (pre_tx > 0) chk("tx_data", {8'h00, tx_data}, {8'h00, txq[0]});
    chk("baud_load", {15'h0, baud_load}, {15'h0, m_bl});
    chk("baud_en", {15'h0, baud_en}, {15'h0, m_en});
    chk("divisor", divisor, m_div);

    wr = cs && !rw;
    rd = cs && rw;
    en_old = m_en;
    if (en_old && pre_tx > 0 && trdy) void'(txq.pop_front());
    if (wr && a == 2'd0) begin
      if (pre_tx < D) txq.push_back(wd);
      else m_txovf = 1;
    end
    rpop = rd && a == 2'd0 && pre_rx > 0;
    if (rpop) void'(rxq.pop_front());
    if (wr && a == 2'd1) begin
      m_en = wd[0];
      if (wd[2]) m_rxovr = 0;
      if (wd[4]) m_txovf = 0;
    end
    if (rxv && en_old) begin
      if (pre_rx < D || rpop) rxq.push_back(rxd);
      else m_rxovr = 1;
    end
    if (wr && a == 2'd2) m_stage = wd;
    if (wr && a == 2'd3) m_div = {wd, m_stage};
    m_bl = wr && a == 2'd3;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [7:0] d);
    step(1, 0, a, d, 0, 0, 0, 8'h00);
  endtask

  task automatic rd_reg(input logic [1:0] a, input int lit = -1);
    step(1, 1, a, 8'h00, 0, 0, 0, 8'h00, lit);
  endtask

  task automatic idle(input logic trdy = 0);
    step(0, 0, 2'd0, 8'h00, trdy, 0, 0, 8'h00);
  endtask

  initial begin
    rst = 1'b1;
    iocs = 0; iorw = 0; ioaddr = 0; wdata = 0;
    tx_ready = 0; tx_busy = 0; rx_valid = 0; rx_data = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset values
    rd_reg(2'd1, 8'h09);
    rd_reg(2'd2, 8'h46);
    rd_reg(2'd3, 8'h01);
    idle();

    // Divisor staging and atomic commit
    wr_reg(2'd2, 8'h51);
    rd_reg(2'd2, 8'h46);
    wr_reg(2'd3, 8'h00);
    chk("div_commit", divisor, 16'h0051);
    chk("bl_pulse", {15'h0, baud_load}, 16'h0001);
    idle();
    idle();
    wr_reg(2'd3, 8'h01);
    wr_reg(2'd3, 8'h01);
    chk("bl_b2b", {15'h0, baud_load}, 16'h0001);
    idle();

    // TX fill with engine stalled, overflow, then drain in order
    wr_reg(2'd1, 8'h01);
    for (int i = 0; i < 5; i++) wr_reg(2'd0, 8'h11 + 8'(i));
    rd_reg(2'd1, 8'h30);
    for (int i = 0; i < 4; i++) begin
      chk("tx_order", {8'h00, tx_data}, {8'h00, 8'h11 + 8'(i)});
      idle(1);
    end
    rd_reg(2'd1, 8'h39);
    wr_reg(2'd1, 8'h11);

    // RX overrun and drain
    for (int i = 0; i < 5; i++) step(0, 0, 2'd0, 8'h00, 0, 0, 1, 8'hA0 + 8'(i));
    rd_reg(2'd1, 8'h2F);
    for (int i = 0; i < 4; i++) rd_reg(2'd0, 8'hA0 + i);
    rd_reg(2'd1, 8'h2D);
    wr_reg(2'd1, 8'h05);
    rd_reg(2'd1, 8'h29);

    // RX full with coincident CPU read: byte accepted, no overrun
    for (int i = 0; i < 4; i++) step(0, 0, 2'd0, 8'h00, 0, 0, 1, 8'hB0 + 8'(i));
    step(1, 1, 2'd0, 8'h00, 0, 0, 1, 8'hB4, 8'hB0);
    rd_reg(2'd1, 8'h2B);
    for (int i = 0; i < 4; i++) rd_reg(2'd0, 8'hB1 + i);

    // Disabled: rx_valid ignored, TX retained but not offered
    wr_reg(2'd1, 8'h00);
    step(0, 0, 2'd0, 8'h00, 0, 0, 1, 8'h77);
    wr_reg(2'd0, 8'h42);
    idle(1);
    wr_reg(2'd1, 8'h01);
    idle(1);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic [1:0] a;
      logic [7:0] d;
      a = 2'($urandom_range(0, 3));
      d = 8'($urandom);
      if (a == 2'd1 && ($urandom_range(0, 3) != 0)) d[0] = 1'b1;
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, d,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 9) < 3), 8'($urandom));
    end

    // Reset in the middle of a transfer
    wr_reg(2'd1, 8'h01);
    for (int i = 0; i < 3; i++) wr_reg(2'd0, 8'hC0 + 8'(i));
    chk("pre_rst_valid", {15'h0, tx_valid}, 16'h0001);
    iocs = 0; ioaddr = 2'd1;
    rst = 1'b1;
    #1;
    chk("rst_tx_valid", {15'h0, tx_valid}, 16'h0000);
    chk("rst_status", {8'h00, rdata}, 16'h0009);
    chk("rst_divisor", divisor, 16'd326);
    chk("rst_baud_en", {15'h0, baud_en}, 16'h0000);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    rd_reg(2'd1, 8'h09);
    rd_reg(2'd3, 8'h01);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spart_bus_ctrl.md
Name: spart_bus_ctrl

Overview:
Processor-facing register and buffer controller for the SPART serial port. It decodes the 2-bit I/O address space and owns the 16-bit baud divisor, delivering it to the baud generator as an atomic load. It buffers transmit bytes toward the TX shift engine and receive bytes from the RX shift engine in small FIFOs, and reports status. It sits between the CPU I/O bus and the baud generator plus shift engines.

Parameters:
FIFO_DEPTH, 4, entries per TX and RX FIFO; must be a power of 2 and at least 2.
DEF_DIVISOR, 16'd326, divisor loaded at reset (9600 baud at 50 MHz, n=4).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
iocs  in  1  I/O chip select; one access per cycle while high
iorw  in  1  1 = read, 0 = write
ioaddr  in  2  00 data, 01 status/command, 10 DB low, 11 DB high
wdata  in  8  CPU write data
rdata  out  8  CPU read data; combinational from current state
divisor  out  16  committed baud divisor
baud_load  out  1  one-cycle pulse when divisor changes
baud_en  out  1  enable to baud generator (= cmd enable bit)
tx_data  out  8  head of TX FIFO
tx_valid  out  1  TX FIFO non-empty and enabled
tx_ready  in  1  TX engine accepts tx_data when tx_valid and tx_ready
tx_busy  in  1  TX engine shifting
rx_data  in  8  received byte
rx_valid  in  1  one-cycle strobe from RX engine

Behaviour:
- Reset (async, rst=1): both FIFOs empty; divisor=DEF_DIVISOR; staged low byte=DEF_DIVISOR[7:0]; enable=0; sticky flags=0; baud_load=0, tx_valid=0, baud_en=0. rdata reflects the reset state. Reset mid-transfer discards all FIFO contents.
- Access decode: wr = iocs & ~iorw, rd = iocs & iorw. All state updates occur on the clk edge ending the access cycle.
- Addr 00 write: push wdata to TX FIFO. If the FIFO is full (evaluated before any same-cycle pop), drop the byte and set tx_ovf.
- Addr 00 read: rdata = RX head (0x00 if empty). Pop if non-empty. An empty read has no effect.
- Addr 01 read, status: [0] tx_space (TX not full), [1] rx_avail, [2] rx_ovr, [3] tx_idle (TX empty & ~tx_busy), [4] tx_ovf, [5] enable, [7:6] 0.
- Addr 01 write, command: bit0 -> enable. bit2=1 clears rx_ovr. bit4=1 clears tx_ovf. Other bits are ignored.
- Addr 10 write: stage the low byte only. divisor is unchanged and no pulse is issued.
- Addr 11 write: divisor <= {wdata, staged_low} in one edge, and baud_load=1 on the following cycle only. Back-to-back DB-high writes produce back-to-back pulses.
- Addr 10/11 read: return divisor[7:0] / divisor[15:8] (committed value, not staged).
- A divisor value of 0 is accepted as written; guarding against it is software's responsibility.
- TX handoff: tx_valid = enable & ~tx_empty. Pop when tx_valid & tx_ready. Same-cycle CPU push and engine pop are both honoured, except the push is dropped if the FIFO was full.
- RX capture: on rx_valid & enable, push rx_data. If the FIFO is full and no same-cycle CPU pop occurs, drop the byte and set rx_ovr. If a CPU pop occurs the same cycle, accept the byte. rx_valid with enable=0 is ignored silently.
- Disable (enable=0): FIFO contents are retained, tx_valid is forced low, and baud_en is low. A byte already handed to the engine is the engine's concern.
- FIFO counters are width clog2(FIFO_DEPTH)+1 and pointers wrap modulo FIFO_DEPTH.

Decomposition:
- Package spart_pkg holds:
  - ioaddr enum (ADDR_DATA, ADDR_STAT, ADDR_DBL, ADDR_DBH);
  - status/command bit-index constants;
  - default divisor constant.
- Sub-module sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count), instantiated for both TX and RX.
- Decode, divisor, and flags logic live in the top module.

Test Plan:
- Reset, then read addr 01 -> 0x09 (tx_space, tx_idle). Read 10/11 -> 0x46/0x01. No baud_load pulse.
- Write 10=0x51, read 10 -> still 0x46. Write 11=0x00 -> divisor=0x0051, single baud_load pulse on the next cycle.
- Enable, hold tx_ready=0, write bytes 0x11..0x15 to 00 -> first 4 queued, 5th dropped, status tx_ovf=1. Raise tx_ready -> 0x11,0x12,0x13,0x14 delivered in order.
- Enable, 5 rx_valid strobes 0xA0..0xA4 -> rx_ovr=1. Four reads of 00 return 0xA0..0xA3, then rx_avail=0. Write 01=0x05 -> rx_ovr cleared.
- RX FIFO full, rx_valid coincident with a CPU data read -> read returns old head, new byte accepted, rx_ovr stays 0.
- Assert rst mid-TX with 3 queued bytes -> tx_valid=0 immediately, status back to reset value, divisor=326.
